// File: rtl/hls_deadlock_reporter.sv
// Purpose : confirms a sustained HLS deadlock-monitor block and emits one timestamped snapshot record per episode.
// Latency : record valid and sticky flag are visible the cycle after the THRESHOLD-th consecutive blocked cycle.
// Backpressure: the record is held stable with report_valid high until report_ready; no re-report until block drops.
//
// Ports:
//   clock, reset           single rising-edge clock, synchronous active-high reset
//   monitor_block          registered block flag from the deadlock monitor
//   axis_block_sigs        raw per-channel block flags, captured at confirmation
//   clear                  single-cycle pulse clearing deadlock_flag only
//   report_valid/ready     valid-ready stream carrying report_data = {timestamp, snapshot}
//   deadlock_flag          sticky deadlock indicator
//   report_count           saturating count of accepted reports
module hls_deadlock_reporter #(
    parameter int THRESHOLD = 1024,
    parameter int SIG_W     = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                monitor_block,
    input  logic [SIG_W-1:0]    axis_block_sigs,
    input  logic                clear,
    input  logic                report_ready,
    output logic                report_valid,
    output logic [32+SIG_W-1:0] report_data,
    output logic                deadlock_flag,
    output logic [7:0]          report_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WATCH  = 2'd1,
        S_REPORT = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    // Last run-count value before confirmation: the cycle that entered WATCH
    // is counted as cycle 1, so cnt==THRESHOLD-1 marks the THRESHOLD-th cycle.
    localparam logic [15:0] CNT_LAST = 16'(THRESHOLD - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [15:0]        r_cnt;
    logic [15:0]        w_cnt_nxt;
    logic [31:0]        r_ts;
    logic [31:0]        r_cap_ts;
    logic [SIG_W-1:0]   r_cap_sig;
    logic               r_flag;
    logic [7:0]         r_count;
    logic               w_confirm;
    logic               w_accept;

    // report_valid comes straight from the state register, so it never
    // depends combinationally on report_ready.
    assign report_valid  = (r_state == S_REPORT);
    assign report_data   = {r_cap_ts, r_cap_sig};
    assign deadlock_flag = r_flag;
    assign report_count  = r_count;
    assign w_accept      = report_valid & report_ready;

    // Next-state and run-counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_confirm   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = 16'd0;
                if (monitor_block) begin
                    w_state_nxt = S_WATCH;
                    w_cnt_nxt   = 16'd1;
                end
            end
            S_WATCH: begin
                if (!monitor_block) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 16'd0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_REPORT;
                    w_confirm   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            S_REPORT: begin
                // monitor_block is deliberately ignored until the record is taken.
                if (report_ready) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                // Stay parked while block persists so one episode yields one report.
                if (!monitor_block) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 16'd0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 16'd0;
            end
        endcase
    end

    // State register and run counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Free-running timestamp; natural 32-bit wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ts <= 32'd0;
        end else begin
            r_ts <= r_ts + 32'd1;
        end
    end

    // Snapshot record: loaded only on confirmation, so it stays stable for the
    // whole REPORT stay and keeps its last value afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cap_ts  <= 32'd0;
            r_cap_sig <= '0;
        end else if (w_confirm) begin
            r_cap_ts  <= r_ts;
            r_cap_sig <= axis_block_sigs;
        end
    end

    // Sticky flag: a confirmation in the same cycle as clear keeps the flag set.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_flag <= 1'b0;
        end else if (w_confirm) begin
            r_flag <= 1'b1;
        end else if (clear) begin
            r_flag <= 1'b0;
        end
    end

    // Accepted-report counter, saturating at 255.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= 8'd0;
        end else if (w_accept && (r_count != 8'hFF)) begin
            r_count <= r_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_hls_deadlock_reporter.sv
// Purpose : directed self-checking bench for hls_deadlock_reporter with THRESHOLD=4, SIG_W=5.
// Latency : inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Backpressure: report_ready is driven per scenario to exercise stalled and immediate acceptance.
module tb_hls_deadlock_reporter;

    localparam int THR = 4;
    localparam int SW  = 5;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               monitor_block = 1'b0;
    logic [SW-1:0]      axis_block_sigs = '0;
    logic               clear = 1'b0;
    logic               report_ready = 1'b0;
    logic               report_valid;
    logic [32+SW-1:0]   report_data;
    logic               deadlock_flag;
    logic [7:0]         report_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_ts     = 32'd0;   // timestamp the DUT evaluates at the next edge
    logic [31:0] edge_ts  = 32'd0;   // timestamp seen at the most recent edge

    hls_deadlock_reporter #(
        .THRESHOLD (THR),
        .SIG_W     (SW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .monitor_block   (monitor_block),
        .axis_block_sigs (axis_block_sigs),
        .clear           (clear),
        .report_ready    (report_ready),
        .report_valid    (report_valid),
        .report_data     (report_data),
        .deadlock_flag   (deadlock_flag),
        .report_count    (report_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        edge_ts = m_ts;
        m_ts    = reset ? 32'd0 : m_ts + 32'd1;
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time expired, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          saw;
        int            nvalid;
        logic [31:0]   conf_ts;
        logic [36:0]   exp_rec;
        logic          pat [8];

        // ---- reset state ----
        repeat (3) tick();
        chk("rst_valid", 64'(report_valid), 64'd0);
        chk("rst_flag",  64'(deadlock_flag), 64'd0);
        chk("rst_count", 64'(report_count), 64'd0);
        chk("rst_data",  64'(report_data), 64'd0);

        // ---- basic confirmation from timestamp 10 ----
        reset = 1'b0;
        repeat (10) tick();
        monitor_block   = 1'b1;
        axis_block_sigs = 5'b00100;
        report_ready    = 1'b1;
        repeat (3) tick();
        chk("basic_pre_valid", 64'(report_valid), 64'd0);
        tick();
        chk("basic_valid", 64'(report_valid), 64'd1);
        chk("basic_data",  64'(report_data), 64'({32'd13, 5'b00100}));
        chk("basic_flag",  64'(deadlock_flag), 64'd1);
        chk("basic_count_pre", 64'(report_count), 64'd0);
        monitor_block = 1'b0;
        tick();
        chk("basic_valid_1cyc", 64'(report_valid), 64'd0);
        chk("basic_count", 64'(report_count), 64'd1);
        chk("basic_flag_sticky", 64'(deadlock_flag), 64'd1);
        tick();

        // ---- interrupted block never confirms ----
        pulse_clear();
        chk("clr_flag",  64'(deadlock_flag), 64'd0);
        chk("clr_count", 64'(report_count), 64'd1);
        pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            monitor_block = pat[i];
            tick();
            saw |= report_valid;
        end
        chk("gap_no_valid", 64'(saw), 64'd0);
        chk("gap_flag", 64'(deadlock_flag), 64'd0);

        // ---- stalled handshake: 5 cycles not ready, then ready ----
        monitor_block   = 1'b1;
        report_ready    = 1'b0;
        axis_block_sigs = 5'b10011;
        repeat (4) tick();
        conf_ts = edge_ts;
        exp_rec = {conf_ts, 5'b10011};
        nvalid  = 0;
        for (int i = 0; i < 6; i++) begin
            if (report_valid) nvalid++;
            chk("stall_data", 64'(report_data), 64'(exp_rec));
            axis_block_sigs = 5'($urandom);
            if (i == 5) report_ready = 1'b1;
            tick();
        end
        chk("stall_nvalid", 64'(nvalid), 64'd6);
        chk("stall_valid_drop", 64'(report_valid), 64'd0);
        chk("stall_count", 64'(report_count), 64'd2);
        monitor_block = 1'b0;
        tick();

        // ---- long block gives exactly one report; re-arm after drop ----
        monitor_block = 1'b1;
        repeat (4) tick();
        chk("long_valid", 64'(report_valid), 64'd1);
        tick();
        chk("long_count1", 64'(report_count), 64'd3);
        saw = 1'b0;
        repeat (100) begin
            tick();
            saw |= report_valid;
        end
        chk("long_no_rereport", 64'(saw), 64'd0);
        chk("long_count_hold", 64'(report_count), 64'd3);
        monitor_block = 1'b0;
        tick();
        monitor_block = 1'b1;
        repeat (4) tick();
        chk("rearm_valid", 64'(report_valid), 64'd1);
        tick();
        chk("rearm_count", 64'(report_count), 64'd4);
        monitor_block = 1'b0;
        tick();

        // ---- clear coinciding with confirmation: set wins ----
        pulse_clear();
        chk("coinc_pre_flag", 64'(deadlock_flag), 64'd0);
        monitor_block = 1'b1;
        report_ready  = 1'b0;
        repeat (3) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("coinc_flag", 64'(deadlock_flag), 64'd1);
        chk("coinc_valid", 64'(report_valid), 64'd1);
        report_ready = 1'b1;
        tick();
        chk("coinc_count", 64'(report_count), 64'd5);
        monitor_block = 1'b0;
        pulse_clear();
        chk("late_clr_flag", 64'(deadlock_flag), 64'd0);
        chk("late_clr_count", 64'(report_count), 64'd5);
        tick();

        // ---- reset while a report is pending ----
        monitor_block   = 1'b1;
        report_ready    = 1'b0;
        axis_block_sigs = 5'b01010;
        repeat (4) tick();
        chk("mid_valid", 64'(report_valid), 64'd1);
        reset = 1'b1;
        tick();
        chk("mid_rst_valid", 64'(report_valid), 64'd0);
        chk("mid_rst_count", 64'(report_count), 64'd0);
        chk("mid_rst_flag",  64'(deadlock_flag), 64'd0);
        chk("mid_rst_data",  64'(report_data), 64'd0);
        reset = 1'b0;
        repeat (3) tick();
        chk("post_rst_pre_valid", 64'(report_valid), 64'd0);
        tick();
        chk("post_rst_valid", 64'(report_valid), 64'd1);
        chk("post_rst_data", 64'(report_data), 64'({32'd3, 5'b01010}));
        report_ready = 1'b1;
        tick();
        chk("post_rst_count", 64'(report_count), 64'd1);
        monitor_block = 1'b0;
        tick();

        // ---- report_count saturation ----
        for (int i = 0; i < 256; i++) begin
            monitor_block = 1'b1;
            repeat (4) tick();
            tick();
            monitor_block = 1'b0;
            tick();
            if (i == 253) chk("sat_count_254", 64'(report_count), 64'd255);
        end
        chk("sat_count", 64'(report_count), 64'd255);
        chk("sat_flag", 64'(deadlock_flag), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
